// File: rtl/alu_port_dispatcher_pkg.sv
// Shared ALU packet/command types plus the per-bank tracking types used by the
// four-bank ALU port dispatcher.
package alu_port_dispatcher_pkg;

  typedef enum logic [3:0] {
    NOP  = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    BAND = 4'd3,
    BOR  = 4'd4,
    BXOR = 4'd5,
    SHL  = 4'd6,
    SHR  = 4'd7
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    INVALID     = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t command;
    logic [31:0]    data1;
    logic [31:0]    data2;
  } input_packet_t;

  typedef struct packed {
    response_names_t response;
    logic [31:0]     data;
  } output_packet_t;

  typedef enum logic [1:0] {
    BANK_IDLE  = 2'd0,
    BANK_ISSUE = 2'd1,
    BANK_WAIT  = 2'd2,
    BANK_DONE  = 2'd3
  } bank_state_t;

  typedef struct packed {
    logic [31:0]     data;
    response_names_t response;
    logic            timeout;
  } bank_result_t;

  localparam int         NUM_BANKS          = 4;
  localparam logic [1:0] INITIAL_LAST_GRANT = 2'd3;

  // First set bit of mask, searching upward from the bank after last (wrapping).
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= NUM_BANKS; k++) begin
      idx = last + 2'(k);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu_port_dispatcher_bank.sv
// One ALU bank: IDLE/ISSUE/WAIT/DONE sequencer, operand latches, result
// capture and the WAIT timeout counter.
module alu_bank_tracker
  import alu_port_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           accept,
  input  command_names_t command,
  input  logic [31:0]    data1,
  input  logic [31:0]    data2,
  input  logic           grant_done,
  input  output_packet_t alu_result,
  output bank_state_t    state,
  output input_packet_t  issue_packet,
  output bank_result_t   result
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  bank_state_t    state_r;
  bank_state_t    state_next_s;
  command_names_t command_r;
  logic [31:0]    data1_r;
  logic [31:0]    data2_r;
  logic [7:0]     count_r;
  bank_result_t   result_r;
  logic           respond_s;
  logic           expire_s;

  assign respond_s = (alu_result.response != NO_RESPONSE);
  // Expiry fires on the cycle whose increment would reach the limit.
  assign expire_s  = ((count_r + 8'd1) == TIMEOUT_LIMIT);

  // State register, operand latches, timeout counter and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= BANK_IDLE;
      command_r <= NOP;
      data1_r   <= 32'd0;
      data2_r   <= 32'd0;
      count_r   <= 8'd0;
      result_r  <= '{data: 32'd0, response: NO_RESPONSE, timeout: 1'b0};
    end else begin
      state_r <= state_next_s;
      if (state_r == BANK_IDLE && accept) begin
        command_r <= command;
        data1_r   <= data1;
        data2_r   <= data2;
      end
      if (state_r == BANK_ISSUE) begin
        count_r <= 8'd0;
      end else if (state_r == BANK_WAIT) begin
        count_r <= count_r + 8'd1;
      end
      if (state_r == BANK_WAIT && respond_s) begin
        result_r <= '{data: alu_result.data, response: alu_result.response, timeout: 1'b0};
      end else if (state_r == BANK_WAIT && expire_s) begin
        result_r <= '{data: 32'd0, response: NO_RESPONSE, timeout: 1'b1};
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BANK_IDLE: begin
        if (accept) state_next_s = BANK_ISSUE;
        else        state_next_s = BANK_IDLE;
      end
      BANK_ISSUE: state_next_s = BANK_WAIT;
      BANK_WAIT: begin
        if (respond_s || expire_s) state_next_s = BANK_DONE;
        else                       state_next_s = BANK_WAIT;
      end
      BANK_DONE: begin
        if (grant_done) state_next_s = BANK_IDLE;
        else            state_next_s = BANK_DONE;
      end
      default: state_next_s = BANK_IDLE;
    endcase
  end

  // ALU drive: the latched command only during the single ISSUE cycle.
  always_comb begin
    issue_packet = '{command: NOP, data1: 32'd0, data2: 32'd0};
    if (state_r == BANK_ISSUE) begin
      issue_packet = '{command: command_r, data1: data1_r, data2: data2_r};
    end else begin
      issue_packet = '{command: NOP, data1: 32'd0, data2: 32'd0};
    end
  end

  assign state  = state_r;
  assign result = result_r;

endmodule

// File: rtl/alu_port_dispatcher.sv
// Host-facing dispatcher over four ALU banks: routes requests to per-bank
// trackers and returns results through a stall-stable round-robin arbiter.
module alu_port_dispatcher
  import alu_port_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_port,
  input  command_names_t        req_command,
  input  logic [31:0]           req_data1,
  input  logic [31:0]           req_data2,
  output input_packet_t [3:0]   input_packet,
  input  output_packet_t [3:0]  output_packet,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_port,
  output logic [31:0]           rsp_data,
  output response_names_t       rsp_response,
  output logic                  rsp_timeout
);

  bank_state_t  bank_state_s  [NUM_BANKS];
  bank_result_t bank_result_s [NUM_BANKS];
  logic [3:0]   accept_s;
  logic [3:0]   grant_done_s;
  logic [3:0]   done_mask_s;
  logic [1:0]   sel_s;
  logic         rsp_handshake_s;
  logic [1:0]   last_r;
  logic         hold_r;
  logic [1:0]   hold_sel_r;

  assign req_ready = !reset && (bank_state_s[req_port] == BANK_IDLE);

  // Per-bank request accept (NOPs complete the handshake but start nothing) and DONE mask.
  always_comb begin
    accept_s    = 4'b0000;
    done_mask_s = 4'b0000;
    for (int i = 0; i < NUM_BANKS; i++) begin
      accept_s[i]    = req_valid && req_ready && (req_port == 2'(i)) && (req_command != NOP);
      done_mask_s[i] = (bank_state_s[i] == BANK_DONE);
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    alu_bank_tracker #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bank (
      .clock       (clock),
      .reset       (reset),
      .accept      (accept_s[g]),
      .command     (req_command),
      .data1       (req_data1),
      .data2       (req_data2),
      .grant_done  (grant_done_s[g]),
      .alu_result  (output_packet[g]),
      .state       (bank_state_s[g]),
      .issue_packet(input_packet[g]),
      .result      (bank_result_s[g])
    );
  end

  assign rsp_valid       = |done_mask_s;
  assign rsp_handshake_s = rsp_valid && rsp_ready;

  // A stalled grant is frozen so later DONE banks cannot steal the output.
  always_comb begin
    sel_s = 2'd0;
    if (hold_r) begin
      sel_s = hold_sel_r;
    end else begin
      sel_s = rr_pick(done_mask_s, last_r);
    end
  end

  // Release only the granted bank on a response handshake.
  always_comb begin
    grant_done_s = 4'b0000;
    for (int i = 0; i < NUM_BANKS; i++) begin
      grant_done_s[i] = rsp_handshake_s && (sel_s == 2'(i));
    end
  end

  // Round-robin pointer and stall hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r     <= INITIAL_LAST_GRANT;
      hold_r     <= 1'b0;
      hold_sel_r <= 2'd0;
    end else if (rsp_handshake_s) begin
      last_r <= sel_s;
      hold_r <= 1'b0;
    end else if (rsp_valid) begin
      hold_r     <= 1'b1;
      hold_sel_r <= sel_s;
    end else begin
      hold_r <= 1'b0;
    end
  end

  // Response fields from the granted bank, zero when nothing is pending.
  always_comb begin
    rsp_port     = 2'd0;
    rsp_data     = 32'd0;
    rsp_response = NO_RESPONSE;
    rsp_timeout  = 1'b0;
    if (rsp_valid) begin
      rsp_port     = sel_s;
      rsp_data     = bank_result_s[sel_s].data;
      rsp_response = bank_result_s[sel_s].response;
      rsp_timeout  = bank_result_s[sel_s].timeout;
    end else begin
      rsp_port     = 2'd0;
      rsp_data     = 32'd0;
      rsp_response = NO_RESPONSE;
      rsp_timeout  = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_port_dispatcher.sv
// Directed bench for alu_port_dispatcher: a vector table of single operations
// plus hand-written contention, stall, timeout, NOP/stray and reset sequences.
module tb_alu_port_dispatcher;
  import alu_port_dispatcher_pkg::*;

  localparam int TO = 10;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_port;
  command_names_t       req_command;
  logic [31:0]          req_data1;
  logic [31:0]          req_data2;
  input_packet_t [3:0]  input_packet;
  output_packet_t [3:0] output_packet;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_port;
  logic [31:0]          rsp_data;
  response_names_t      rsp_response;
  logic                 rsp_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  alu_port_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_port     (req_port),
    .req_command  (req_command),
    .req_data1    (req_data1),
    .req_data2    (req_data2),
    .input_packet (input_packet),
    .output_packet(output_packet),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_port     (rsp_port),
    .rsp_data     (rsp_data),
    .rsp_response (rsp_response),
    .rsp_timeout  (rsp_timeout)
  );

  typedef struct {
    logic [1:0]      port;
    command_names_t  cmd;
    logic [31:0]     d1;
    logic [31:0]     d2;
    logic [31:0]     exp_data;
    response_names_t exp_resp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Bench ALU model: computes a response from what the DUT presented.
  function automatic logic [31:0] alu_data(input command_names_t c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      BAND:    return a & b;
      BOR:     return a | b;
      BXOR:    return a ^ b;
      SHL:     return a << b[4:0];
      SHR:     return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic response_names_t alu_resp(input command_names_t c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (c == ADD && sum[32]) return OVERFLOW;
    return SUCCESS;
  endfunction

  task automatic issue(input logic [1:0] p, input command_names_t c, input logic [31:0] a, input logic [31:0] b);
    req_valid   = 1'b1;
    req_port    = p;
    req_command = c;
    req_data1   = a;
    req_data2   = b;
    #1;
    check("issue_ready", 32'(req_ready), 32'd1);
    step();
    req_valid   = 1'b0;
    req_command = NOP;
  endtask

  task automatic respond(input logic [1:0] p, input logic [31:0] d);
    output_packet[p].response = SUCCESS;
    output_packet[p].data     = d;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  command_names_t seen_cmd;
  logic [31:0]    seen_a;
  logic [31:0]    seen_b;
  int             waited;
  int             seen_valid;

  initial begin
    vecs[0] = '{2'd2, ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, SUCCESS};
    vecs[1] = '{2'd0, SUB,  32'h0000_000A, 32'h0000_0003, 32'h0000_0007, SUCCESS};
    vecs[2] = '{2'd1, BXOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, SUCCESS};
    vecs[3] = '{2'd3, SHL,  32'h0000_0001, 32'h0000_0004, 32'h0000_0010, SUCCESS};
    vecs[4] = '{2'd2, ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, OVERFLOW};

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_port      = 2'd0;
    req_command   = NOP;
    req_data1     = 32'd0;
    req_data2     = 32'd0;
    rsp_ready     = 1'b0;
    output_packet = '0;

    // Reset state
    step();
    step();
    for (int p = 0; p < 4; p++) begin
      check("rst_cmd", 32'(input_packet[p].command), 32'(NOP));
      check("rst_data", input_packet[p].data1 | input_packet[p].data2, 32'd0);
    end
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fields", {rsp_data[29:0], 2'b00} | 32'(rsp_port) | 32'(rsp_response) | 32'(rsp_timeout), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      req_port = 2'(p);
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end

    // Table-driven single operations
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].port, vecs[i].cmd, vecs[i].d1, vecs[i].d2);
      check("issue_cmd", 32'(input_packet[vecs[i].port].command), 32'(vecs[i].cmd));
      check("issue_d1", input_packet[vecs[i].port].data1, vecs[i].d1);
      check("issue_d2", input_packet[vecs[i].port].data2, vecs[i].d2);
      seen_cmd = input_packet[vecs[i].port].command;
      seen_a   = input_packet[vecs[i].port].data1;
      seen_b   = input_packet[vecs[i].port].data2;
      req_port = vecs[i].port;
      #1;
      check("busy_ready", 32'(req_ready), 32'd0);
      step();
      check("one_issue_cycle", 32'(input_packet[vecs[i].port].command), 32'(NOP));
      output_packet[vecs[i].port].response = alu_resp(seen_cmd, seen_a, seen_b);
      output_packet[vecs[i].port].data     = alu_data(seen_cmd, seen_a, seen_b);
      step();
      output_packet = '0;
      check("op_rsp_valid", 32'(rsp_valid), 32'd1);
      check("op_rsp_port", 32'(rsp_port), 32'(vecs[i].port));
      check("op_rsp_data", rsp_data, vecs[i].exp_data);
      check("op_rsp_response", 32'(rsp_response), 32'(vecs[i].exp_resp));
      check("op_rsp_timeout", 32'(rsp_timeout), 32'd0);
      check("done_ready", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      check("op_rsp_cleared", 32'(rsp_valid), 32'd0);
      check("op_ready_again", 32'(req_ready), 32'd1);
    end

    // All four banks respond together; bank 0 first after reset
    reset_dut();
    for (int p = 0; p < 4; p++) issue(2'(p), ADD, 32'(p), 32'd1);
    step();
    step();
    for (int p = 0; p < 4; p++) respond(2'(p), 32'h100 + 32'(p));
    rsp_ready = 1'b1;
    step();
    output_packet = '0;
    for (int j = 0; j < 4; j++) begin
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_port", 32'(rsp_port), 32'(j));
      check("rr_data", rsp_data, 32'h100 + 32'(j));
      step();
    end
    rsp_ready = 1'b0;
    check("rr_drained", 32'(rsp_valid), 32'd0);

    // Stall: bank 1 granted, banks 0/2 finish later but output stays on bank 1
    for (int p = 0; p < 4; p++) issue(2'(p), SUB, 32'd9, 32'(p));
    step();
    step();
    respond(2'd1, 32'h201);
    respond(2'd3, 32'h203);
    step();
    output_packet = '0;
    respond(2'd0, 32'h200);
    respond(2'd2, 32'h202);
    step();
    output_packet = '0;
    for (int j = 0; j < 5; j++) begin
      check("stall_port", 32'(rsp_port), 32'd1);
      check("stall_data", rsp_data, 32'h201);
      step();
    end
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("stall_order", 32'(rsp_port), 32'((j + 1) % 4));
      check("stall_order_data", rsp_data, 32'h200 + 32'((j + 1) % 4));
      step();
    end
    rsp_ready = 1'b0;
    check("stall_drained", 32'(rsp_valid), 32'd0);

    // Timeout on bank 1: one ISSUE cycle plus TO WAIT cycles
    issue(2'd1, SUB, 32'd9, 32'd4);
    waited = 0;
    while (!rsp_valid && waited < 40) begin
      step();
      waited++;
    end
    check("timeout_latency", 32'(waited), 32'(TO + 1));
    check("timeout_port", 32'(rsp_port), 32'd1);
    check("timeout_flag", 32'(rsp_timeout), 32'd1);
    check("timeout_data", rsp_data, 32'd0);
    check("timeout_response", 32'(rsp_response), 32'(NO_RESPONSE));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // NOP request and stray response
    req_valid   = 1'b1;
    req_port    = 2'd0;
    req_command = NOP;
    req_data1   = 32'h1234;
    #1;
    check("nop_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("nop_no_issue", 32'(input_packet[0].command), 32'(NOP));
    check("nop_no_data", input_packet[0].data1, 32'd0);
    respond(2'd3, 32'hDEAD);
    step();
    output_packet = '0;
    seen_valid = 0;
    for (int j = 0; j < 14; j++) begin
      if (rsp_valid) seen_valid++;
      step();
    end
    check("nop_stray_no_rsp", 32'(seen_valid), 32'd0);
    req_port = 2'd3;
    #1;
    check("stray_bank_idle", 32'(req_ready), 32'd1);

    // Reset while banks 0 and 1 wait
    issue(2'd0, ADD, 32'd1, 32'd2);
    issue(2'd1, ADD, 32'd3, 32'd4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    respond(2'd0, 32'h55);
    respond(2'd1, 32'h66);
    step();
    output_packet = '0;
    seen_valid = 0;
    for (int j = 0; j < 2 * TO; j++) begin
      if (rsp_valid) seen_valid++;
      step();
    end
    check("midop_rst_no_rsp", 32'(seen_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_port_dispatcher.md
ALU_PORT_DISPATCHER -- requirements
Module: alu_port_dispatcher

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: the number of WAIT cycles without an ALU response before a port times out.
REQ-002 The block SHALL have these ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_port  input  2  target ALU bank 0..3.
- req_command  input  command_names_t  ALU command.
- req_data1, req_data2  input  32 each  operands.
- input_packet  output  input_packet_t[3:0]  drive to ALU banks.
- output_packet  input  output_packet_t[3:0]  ALU bank results.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  host consumes result.
- rsp_port  output  2  bank that produced the result.
- rsp_data  output  32  result data.
- rsp_response  output  response_names_t  ALU response.
- rsp_timeout  output  1  result is a timeout, not an ALU response.

Function
REQ-003 Each bank SHALL have an independent FSM: IDLE, ISSUE, WAIT, DONE.
REQ-004 req_ready SHALL equal (registered state of bank req_port == IDLE) and not reset; it is combinational on req_port.
REQ-005 A handshake (req_valid and req_ready) with a non-NOP command SHALL latch command/data1/data2 into bank req_port; IDLE -> ISSUE.
REQ-006 A handshake with command NOP SHALL be consumed and discarded: no ALU issue, no response, bank stays IDLE.
REQ-007 In ISSUE, input_packet[bank] SHALL carry the latched command and operands for exactly one cycle; ISSUE -> WAIT. In every other state that bank's command field is NOP and its data fields are 0.
REQ-008 Latency: a handshake at edge k SHALL make the command visible on input_packet from edge k to edge k+1.
REQ-009 In WAIT, output_packet[bank].response != NO_RESPONSE SHALL capture data and response into the bank result, clear the timeout flag, and go to DONE.
REQ-010 A response seen on a bank that is not in WAIT (IDLE, ISSUE, DONE) SHALL be ignored.
REQ-011 In WAIT, a per-bank 8-bit counter SHALL increment each cycle. When it reaches TIMEOUT_CYCLES with no response, the bank SHALL go to DONE with data 0, response NO_RESPONSE and timeout flag 1. The counter clears on entry to WAIT.
REQ-012 rsp_valid SHALL be high whenever any bank is in DONE. rsp_port/rsp_data/rsp_response/rsp_timeout present the bank chosen by round-robin, starting at the bank after the last granted bank (initial last-granted = 3, so bank 0 has first priority).
REQ-013 While rsp_valid and not rsp_ready, the selected bank and all rsp_* outputs SHALL stay stable, even if other banks reach DONE.
REQ-014 On rsp_valid and rsp_ready, the selected bank SHALL go DONE -> IDLE and become the last-granted bank. A new request to that bank is accepted no earlier than the next cycle.
REQ-015 Requests to other banks SHALL be accepted in the same cycle as a response handshake; all four banks may be outstanding at once.
REQ-016 Simultaneous responses on several banks SHALL each be captured in their own bank; none is lost.

Reset
REQ-017 While reset is high at an edge, all banks SHALL go to IDLE, counters clear and last-granted becomes 3. Outputs: input_packet all NOP with zero data; rsp_valid 0; rsp_data 0; rsp_response NO_RESPONSE; rsp_timeout 0; rsp_port 0; req_ready 0.
REQ-018 Reset mid-operation SHALL discard all in-flight and DONE results. ALU responses arriving after reset for pre-reset commands are ignored per REQ-010.

Structure
REQ-019 command_names_t, response_names_t, input_packet_t and output_packet_t SHALL come from the existing shared ALU package. The bank state enum and the bank-result struct (data, response, timeout) SHALL be added there.
REQ-020 One sub-module, alu_bank_tracker, SHALL implement one bank's FSM, latches and timeout counter, instantiated 4 times; the round-robin arbiter stays in the top level.

Verification
REQ-021 Reset: hold reset 2 cycles -> input_packet all NOP, rsp_valid 0, req_ready 0; after reset release req_ready 1 for every port.
REQ-022 Single op: port 2, command non-NOP, data1 32'h0000_0005, data2 32'h0000_0003 -> exactly one ISSUE cycle on bank 2. When the ALU responds, rsp_port 2 and rsp_data/rsp_response match output_packet[2]. req_ready for port 2 is low until the response handshake.
REQ-023 Contention: all 4 banks respond in the same cycle, rsp_ready held high -> rsp_port sequence 0,1,2,3 on consecutive cycles. With rsp_ready low for 5 cycles, rsp_* stay stable.
REQ-024 Timeout: ALU model never responds on bank 1, TIMEOUT_CYCLES=10 -> rsp_valid with rsp_port 1, rsp_timeout 1, rsp_data 0 after 10 WAIT cycles.
REQ-025 NOP/stray: NOP request to port 0 -> accepted, no input_packet activity, no response. A stray response on idle bank 3 -> no rsp_valid.
REQ-026 Reset mid-op: reset asserted while banks 0 and 1 are in WAIT -> no response is ever delivered for those commands.
